// File: rtl/vending_arbiter_if.sv
// vending_arbiter_if: panel, vendor and routing signals between the two
// customer panels, the shared vending machine and the arbiter.
// master = environment (panels + vending machine), slave = arbiter.
interface vending_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic [1:0] money_a;
  logic [1:0] money_b;
  logic [1:0] select_a;
  logic [1:0] select_b;
  logic       gnt_a;
  logic       gnt_b;
  logic [1:0] vend_money;
  logic [1:0] vend_select;
  logic [1:0] vend_item;
  logic [1:0] vend_change;
  logic [1:0] item_a;
  logic [1:0] item_b;
  logic [1:0] change_a;
  logic [1:0] change_b;
  logic       coin_drop;

  modport master (
    output req_a, req_b, money_a, money_b, select_a, select_b,
    output vend_item, vend_change,
    input  gnt_a, gnt_b, vend_money, vend_select,
    input  item_a, item_b, change_a, change_b, coin_drop
  );

  modport slave (
    input  req_a, req_b, money_a, money_b, select_a, select_b,
    input  vend_item, vend_change,
    output gnt_a, gnt_b, vend_money, vend_select,
    output item_a, item_b, change_a, change_b, coin_drop
  );
endinterface

// File: rtl/vending_arbiter.sv
// vending_arbiter: grants one of two panels exclusive use of the shared
// vending machine for a whole purchase, forwards only the owner's coin and
// select pulses and routes item/change back to the owner.
// Optional feature macro: VEND_ARB_RR_EN -- round-robin tie-break in IDLE;
// when undefined, panel FIXED_PRIO (0 = A, 1 = B) wins every tie.
module vending_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            reset,
  vending_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_t;

  // Code 11 is illegal on both coin and select lines and is treated as idle.
  function automatic logic [1:0] legal_pulse(input logic [1:0] p);
    legal_pulse = (p == 2'b11) ? 2'b00 : p;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       last_owner_r;   // 0 = A, 1 = B
  logic       last_owner_s;
  logic       tie_pick_b_s;
  logic [1:0] own_money_s;
  logic [1:0] own_select_s;
  logic       completion_s;

  logic       gnt_a_r;
  logic       gnt_b_r;
  logic [1:0] vend_money_r;
  logic [1:0] vend_select_r;
  logic       coin_drop_r;
  logic       gnt_a_s;
  logic       gnt_b_s;
  logic [1:0] vend_money_s;
  logic [1:0] vend_select_s;
  logic       coin_drop_s;

  // Tie-break selection between simultaneous requests in IDLE.
  always_comb begin
`ifdef VEND_ARB_RR_EN
    tie_pick_b_s = ~last_owner_r;
`else
    // Ownership history is still tracked but deliberately masked out here.
    tie_pick_b_s = (FIXED_PRIO != 0) | (last_owner_r & 1'b0);
`endif
  end

  // Select the current owner's sanitized pulses and detect purchase completion.
  always_comb begin
    own_money_s  = 2'b00;
    own_select_s = 2'b00;
    completion_s = 1'b0;
    case (state_r)
      ST_OWN_A: begin
        own_money_s  = legal_pulse(bus.money_a);
        own_select_s = legal_pulse(bus.select_a);
        completion_s = (bus.vend_item != 2'b00);
      end
      ST_OWN_B: begin
        own_money_s  = legal_pulse(bus.money_b);
        own_select_s = legal_pulse(bus.select_b);
        completion_s = (bus.vend_item != 2'b00);
      end
      default: begin
        own_money_s  = 2'b00;
        own_select_s = 2'b00;
        completion_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold ownership until the item appears.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_a && bus.req_b) begin
          next_state_s = tie_pick_b_s ? ST_OWN_B : ST_OWN_A;
        end else if (bus.req_a) begin
          next_state_s = ST_OWN_A;
        end else if (bus.req_b) begin
          next_state_s = ST_OWN_B;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (completion_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if (completion_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_OWN_B;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and ownership history.
  always_comb begin
    gnt_a_s       = (next_state_s == ST_OWN_A);
    gnt_b_s       = (next_state_s == ST_OWN_B);
    vend_money_s  = 2'b00;
    vend_select_s = 2'b00;
    coin_drop_s   = 1'b0;
    last_owner_s  = last_owner_r;
    if (completion_s) begin
      // Pulses on the completion edge are discarded; flag any that were real.
      coin_drop_s = (own_money_s != 2'b00) || (own_select_s != 2'b00);
    end else begin
      vend_money_s  = own_money_s;
      vend_select_s = own_select_s;
    end
    if ((state_r == ST_IDLE) && (next_state_s == ST_OWN_A)) begin
      last_owner_s = 1'b0;
    end else if ((state_r == ST_IDLE) && (next_state_s == ST_OWN_B)) begin
      last_owner_s = 1'b1;
    end else begin
      last_owner_s = last_owner_r;
    end
  end

  // Output and history registers; reset leaves last_owner at B so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_a_r       <= 1'b0;
      gnt_b_r       <= 1'b0;
      vend_money_r  <= 2'b00;
      vend_select_r <= 2'b00;
      coin_drop_r   <= 1'b0;
      last_owner_r  <= 1'b1;
    end else begin
      gnt_a_r       <= gnt_a_s;
      gnt_b_r       <= gnt_b_s;
      vend_money_r  <= vend_money_s;
      vend_select_r <= vend_select_s;
      coin_drop_r   <= coin_drop_s;
      last_owner_r  <= last_owner_s;
    end
  end

  assign bus.gnt_a       = gnt_a_r;
  assign bus.gnt_b       = gnt_b_r;
  assign bus.vend_money  = vend_money_r;
  assign bus.vend_select = vend_select_r;
  assign bus.coin_drop   = coin_drop_r;

  // Vendor results go straight back to the owner only; the grant gates them.
  assign bus.item_a   = gnt_a_r ? bus.vend_item   : 2'b00;
  assign bus.item_b   = gnt_b_r ? bus.vend_item   : 2'b00;
  assign bus.change_a = gnt_a_r ? bus.vend_change : 2'b00;
  assign bus.change_b = gnt_b_r ? bus.vend_change : 2'b00;

endmodule
